// File: rtl/decay_pkg.sv
// Shared constants and types for the potential decay array.
// Rate codes, fp32 field positions, sweep FSM states and a signed-zero helper.
package decay_pkg;

    localparam logic [3:0] RATE_DIV1 = 4'b0001;
    localparam logic [3:0] RATE_DIV2 = 4'b0010;
    localparam logic [3:0] RATE_DIV4 = 4'b0100;
    localparam logic [3:0] RATE_DIV8 = 4'b1000;
    localparam logic [3:0] RATE_075  = 4'b0011;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int MAN_LSB  = 0;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sweep_state_e;

    // Zero of the given sign; used by every flush path.
    function automatic logic [31:0] signed_zero(input logic sign);
        return {sign, 31'b0};
    endfunction

endpackage

// File: rtl/fp_decay_core.sv
// Combinational fp32 leak: applies one decay-rate code to one potential.
// Shift codes subtract from the exponent; 0011 scales by 0.75 with truncation.
// Zero/denormal inputs give signed zero, Inf/NaN pass through unchanged.
module fp_decay_core
    import decay_pkg::*;
(
    input  logic [31:0] potential,
    input  logic [3:0]  rate,
    output logic [31:0] result,
    output logic        underflow
);

    logic        sign;
    logic [7:0]  exp_in;
    logic [22:0] man_in;
    logic [25:0] prod;
    logic [7:0]  shift;

    assign sign   = potential[SIGN_BIT];
    assign exp_in = potential[EXP_MSB:EXP_LSB];
    assign man_in = potential[MAN_MSB:MAN_LSB];

    // 3 * {1, mantissa} formed as s + 2s to avoid a multiplier.
    assign prod = {2'b00, 1'b1, man_in} + {1'b0, 1'b1, man_in, 1'b0};

    // Exponent decrement for the power-of-two codes; unknown codes are identity.
    always_comb begin
        case (rate)
            RATE_DIV2: shift = 8'd1;
            RATE_DIV4: shift = 8'd2;
            RATE_DIV8: shift = 8'd3;
            default:   shift = 8'd0;
        endcase
    end

    // Select the decayed value and flag flushes caused by the decay itself.
    always_comb begin
        result    = potential;
        underflow = 1'b0;
        if (exp_in == 8'd0) begin
            result = signed_zero(sign);
        end else if (exp_in == EXP_MAX) begin
            result = potential;
        end else if (rate == RATE_075) begin
            if (prod[25]) begin
                result = {sign, exp_in, prod[24:2]};
            end else if (exp_in == 8'd1) begin
                result    = signed_zero(sign);
                underflow = 1'b1;
            end else begin
                result = {sign, exp_in - 8'd1, prod[23:1]};
            end
        end else if (shift != 8'd0) begin
            if (exp_in <= shift) begin
                result    = signed_zero(sign);
                underflow = 1'b1;
            end else begin
                result = {sign, exp_in - shift, man_in};
            end
        end
    end

endmodule

// File: rtl/potential_decay_array.sv
// LIF leak stage: per-neuron fp32 potential and rate table, swept once per
// timestep strobe, one neuron per cycle, with write-back and streamed output.
// Optional macro DECAY_UNDERFLOW_CNT_EN adds underflow_cnt[15:0], counting
// neurons flushed by the decay during the current/last sweep (saturating).
module potential_decay_array
    import decay_pkg::*;
#(
    parameter int         NEURONS    = 16,
    parameter int         ADDR_W     = 4,
    parameter logic [3:0] RESET_RATE = 4'b0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_potential,
    input  logic [3:0]        cfg_rate,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [31:0]       upd_potential,
    input  logic              ts_start,
    output logic              busy,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              done
`ifdef DECAY_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       out_pot_q, out_pot_d;
    logic              done_q, done_d;

    logic [31:0]       pot_q  [NEURONS];
    logic [31:0]       pot_d  [NEURONS];
    logic [3:0]        rate_q [NEURONS];
    logic [3:0]        rate_d [NEURONS];

    logic [31:0]       decayed;
    logic              decay_uf;
    logic              last_idx;
    logic              cfg_ok;
    logic              upd_ok;

    assign last_idx = (idx_q == ADDR_W'(NEURONS - 1));
    assign cfg_ok   = cfg_we && (int'(cfg_addr) < NEURONS);
    assign upd_ok   = upd_valid && (int'(upd_addr) < NEURONS);

    fp_decay_core u_core (
        .potential (pot_q[idx_q]),
        .rate      (rate_q[idx_q]),
        .result    (decayed),
        .underflow (decay_uf)
    );

    // Sweep sequencing and next values of the registered output stream.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q;
        out_pot_d   = out_pot_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ts_start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                out_valid_d = 1'b1;
                out_addr_d  = idx_q;
                out_pot_d   = decayed;
                if (last_idx) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Table writes; later assignments win, giving upd > write-back > cfg.
    always_comb begin
        for (int unsigned i = 0; i < NEURONS; i++) begin
            pot_d[i]  = pot_q[i];
            rate_d[i] = rate_q[i];
        end
        if (cfg_ok) begin
            pot_d[cfg_addr]  = cfg_potential;
            rate_d[cfg_addr] = cfg_rate;
        end
        if (state_q == SWEEP) begin
            pot_d[idx_q] = decayed;
        end
        if (upd_ok) begin
            pot_d[upd_addr] = upd_potential;
        end
    end

    // FSM, output registers and table storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_pot_q   <= '0;
            done_q      <= 1'b0;
            for (int unsigned i = 0; i < NEURONS; i++) begin
                pot_q[i]  <= '0;
                rate_q[i] <= RESET_RATE;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_pot_q   <= out_pot_d;
            done_q      <= done_d;
            for (int unsigned i = 0; i < NEURONS; i++) begin
                pot_q[i]  <= pot_d[i];
                rate_q[i] <= rate_d[i];
            end
        end
    end

    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign out_addr      = out_addr_q;
    assign out_potential = out_pot_q;
    assign done          = done_q;

`ifdef DECAY_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Cleared when a sweep is accepted, saturating count of decay flushes.
    always_comb begin
        ucnt_d = ucnt_q;
        if (state_q == IDLE && ts_start) begin
            ucnt_d = '0;
        end else if (state_q == SWEEP && decay_uf && ucnt_q != '1) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    // Underflow counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: doc/potential_decay_array.md
Name: potential_decay_array

Overview:
Clocked, parametrised LIF leak stage for a bank of NEURONS membrane potentials held as IEEE-754 single-precision values. Holds a per-neuron potential and decay-rate table. On each timestep strobe it sweeps every neuron once, applies the neuron's decay, writes the result back and streams it out. Sits between the potential adder (which writes updated potentials) and the spike/threshold stage (which consumes the decayed stream).

Parameters:
NEURONS, 16, number of neurons in the bank (>=2).
ADDR_W, 4, neuron address width; must satisfy 2**ADDR_W >= NEURONS.
RESET_RATE, 4'b0001, decay-rate code loaded into every table entry at reset.

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cfg_we  in  1  write init potential and rate for cfg_addr
cfg_addr  in  ADDR_W  config target neuron
cfg_potential  in  32  initial membrane potential, fp32
cfg_rate  in  4  decay-rate code
upd_valid  in  1  potential adder result valid
upd_addr  in  ADDR_W  neuron being updated
upd_potential  in  32  new potential, fp32
ts_start  in  1  one-cycle timestep strobe; starts a sweep
busy  out  1  sweep in progress
out_valid  out  1  decayed potential valid this cycle
out_addr  out  ADDR_W  neuron of out_potential
out_potential  out  32  decayed potential, fp32
done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset: all potentials 32'h0, all rates RESET_RATE, FSM IDLE, index 0. busy, out_valid, done, out_addr, out_potential all 0.
- FSM IDLE -> SWEEP on ts_start. SWEEP: index i = 0..NEURONS-1, one neuron per cycle. After i = NEURONS-1 -> DONE. DONE lasts one cycle -> IDLE.
- busy = 1 in SWEEP and DONE. ts_start while busy is ignored; it is not queued.
- Per SWEEP cycle i: read pot[i] and rate[i], decay them combinationally, then register. Next cycle: out_valid = 1, out_addr = i, out_potential = result, and pot[i] <= result. Latency is one cycle per neuron.
- out_valid for the last neuron coincides with the DONE cycle; done = 1 in that same cycle.
- Sweep throughput: NEURONS cycles plus one. A ts_start exactly one cycle after done is accepted.
- Rate codes:
  - 0001: divide by 1.
  - 0010: divide by 2, exponent - 1.
  - 0100: divide by 4, exponent - 2.
  - 1000: divide by 8, exponent - 3.
  - 0011: multiply by 0.75 (x/2 + x/4).
  - Any other code: divide by 1.
- Shift modes: if exponent <= shift, flush to signed zero (sign kept, exp = 0, mantissa = 0).
- Mode 0011:
  - s = {1, mantissa} (24 bits), p = 3*s (26 bits).
  - If p[25]: exp = e, mantissa = p[24:2].
  - Otherwise: exp = e - 1, mantissa = p[23:1].
  - Truncate, no rounding. If e = 1 and the result exponent would be 0, flush to signed zero.
- Exponent 0 (zero or denormal) input: output signed zero. Exponent 255 (Inf/NaN) input: passed unchanged.
- Write priority per address in one cycle: upd_valid > sweep write-back > cfg_we. out_potential still shows the decayed value when an upd overwrites the same address.
- cfg_we and upd_valid are accepted at any time, including during a sweep.
- cfg_we writes both the potential and the rate. The potential write is subject to the priority rule above; the rate always takes effect.
- Out-of-range address (>= NEURONS) on cfg or upd: write ignored.
- reset_n asserted mid-sweep: immediate return to reset state, table contents reset, no done pulse.

Optional Feature:
DECAY_UNDERFLOW_CNT_EN
- With it: extra output port underflow_cnt[15:0]. It counts neurons flushed to zero by the shift or 0.75 underflow rule (not zero inputs) and saturates at 16'hFFFF. It is cleared by reset and at the start of each sweep, and is held after done.
- Without it: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package decay_pkg holds:
  - rate-code constants: RATE_DIV1, RATE_DIV2, RATE_DIV4, RATE_DIV8, RATE_075.
  - fp32 field constants: SIGN_BIT, EXP_MSB/LSB, MAN_MSB/LSB, EXP_MAX = 8'hFF.
  - FSM state typedef: IDLE, SWEEP, DONE.
- Sub-module fp_decay_core: purely combinational, inputs potential[31:0] and rate[3:0], outputs result[31:0] and underflow flag. It holds all arithmetic so it can be verified standalone.

Test Plan:
- cfg neuron 0 = 32'h41deb852 (27.84), rate 0010; ts_start -> out_addr 0, out_potential 32'h415eb852; done after NEURONS+1 cycles.
- cfg neuron 1 = 32'h41000000 (8.0), rate 0011 -> 32'h40c00000 (6.0). Same value with rate 1000 -> 32'h3f800000.
- cfg exponent 8'h02 with rate 1000 -> signed zero. 32'hff800000 (-Inf) with any rate -> unchanged. Code 0110 -> identity.
- upd_valid to address k in the same cycle as k's write-back -> table holds upd_potential; out_potential for k shows the decayed value. ts_start while busy -> no second sweep.
- reset_n low during mid-sweep at index 5 -> all outputs 0, no done; the next sweep outputs zeros for every neuron.
- With DECAY_UNDERFLOW_CNT_EN, 3 neurons underflowing -> underflow_cnt = 3 after done, cleared at the next ts_start.
